axi4l_wb_bridge: RTL and testbench

Parametrised AXI4-Lite slave to Wishbone classic master bridge. It is the next-generation front end for the wishbone DSP cores (IIR, FIR, DFT, ...) in their AXI4-Lite wrappers.
- Generalises data/address width.
- Round-robin arbitrates concurrent reads and writes.
- Maps wb_err to SLVERR.
- Adds a bus-hang timeout that returns DECERR instead of stalling the AXI fabric.

---
 rtl/axi4l_wb_pkg.sv | 33 +++
 rtl/wb_timeout_ctr.sv | 41 ++++
 rtl/axi4l_wb_bridge.sv | 160 ++++++++++++++++
 tb/tb_axi4l_wb_bridge.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4l_wb_pkg.sv
// Shared types and constants for the AXI4-Lite to Wishbone bridge.
//   resp_t / RESP_*  : AXI response encodings
//   bridge_state_e   : bridge FSM states
//   grant_e          : round-robin arbiter grant
//   ctr_width()      : timeout counter width for a given cycle limit
package axi4l_wb_pkg;

    typedef logic [1:0] resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;
    localparam resp_t RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WB_WR,
        ST_WB_RD,
        ST_B_RESP,
        ST_R_RESP
    } bridge_state_e;

    typedef enum logic {
        GNT_RD,
        GNT_WR
    } grant_e;

    // A limit of 0 (timeout disabled) still gets a 1-bit counter so the
    // declaration stays legal.
    function automatic int unsigned ctr_width(input int unsigned limit);
        return (limit == 0) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/wb_timeout_ctr.sv
// Saturating bus-hang timeout counter.
//   clk_i, rst_i : clock, async active-high reset
//   clr          : restart the count at zero
//   en           : count one WB cycle
//   expired      : count has reached TIMEOUT_CYCLES (never set when 0)
module wb_timeout_ctr
    import axi4l_wb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CW = ctr_width(TIMEOUT_CYCLES);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_disabled
            assign expired = 1'b0;
        end else begin : g_enabled
            localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
            logic [CW-1:0] cnt;

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    cnt <= '0;
                end else if (clr) begin
                    cnt <= '0;
                end else if (en && (cnt != LIMIT)) begin
                    cnt <= cnt + 1'b1;
                end
            end

            assign expired = (cnt == LIMIT);
        end
    endgenerate

endmodule

// File: rtl/axi4l_wb_bridge.sv
// AXI4-Lite slave to Wishbone classic master bridge.
//   s_aw*/s_w*/s_b*  : AXI write address, data and response channels
//   s_ar*/s_r*       : AXI read address and data channels
//   wb_*             : Wishbone classic master
//   busy_o           : FSM not idle
//   timeout_o        : one-cycle pulse when a WB access is aborted
// One transaction in flight; concurrent read/write requests are granted
// round-robin. wb_err maps to SLVERR, a hung access to DECERR.
module axi4l_wb_bridge
    import axi4l_wb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [ADDR_WIDTH-1:0]   s_awaddr,
    input  logic                    s_awvalid,
    output logic                    s_awready,
    input  logic [DATA_WIDTH-1:0]   s_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_wstrb,
    input  logic                    s_wvalid,
    output logic                    s_wready,
    output logic [1:0]              s_bresp,
    output logic                    s_bvalid,
    input  logic                    s_bready,
    input  logic [ADDR_WIDTH-1:0]   s_araddr,
    input  logic                    s_arvalid,
    output logic                    s_arready,
    output logic [DATA_WIDTH-1:0]   s_rdata,
    output logic [1:0]              s_rresp,
    output logic                    s_rvalid,
    input  logic                    s_rready,
    output logic [ADDR_WIDTH-1:0]   wb_adr_o,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    output logic [DATA_WIDTH/8-1:0] wb_sel_o,
    output logic                    wb_we_o,
    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    input  logic                    wb_ack_i,
    input  logic                    wb_err_i,
    output logic                    busy_o,
    output logic                    timeout_o
);

    bridge_state_e state;
    grant_e        last_gnt;

    logic  idle;
    logic  gnt_wr;
    logic  gnt_rd;
    logic  in_wb;
    logic  expired;
    logic  term;
    resp_t term_resp;

    // Reset is folded in so the combinational readies are low while rst_i
    // is held, even if requests are already pending.
    assign idle   = (state == ST_IDLE) && !rst_i;
    assign gnt_wr = idle && s_awvalid && s_wvalid && (!s_arvalid || (last_gnt == GNT_RD));
    assign gnt_rd = idle && s_arvalid && !gnt_wr;

    assign s_awready = gnt_wr;
    assign s_wready  = gnt_wr;
    assign s_arready = gnt_rd;
    assign busy_o    = (state != ST_IDLE);

    assign in_wb = (state == ST_WB_WR) || (state == ST_WB_RD);

    // Termination priority: ack, then err, then timeout.
    assign term      = wb_ack_i || wb_err_i || expired;
    assign term_resp = wb_ack_i ? RESP_OKAY : (wb_err_i ? RESP_SLVERR : RESP_DECERR);

    wb_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr     (state == ST_IDLE),
        .en      (in_wb),
        .expired (expired)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            last_gnt  <= GNT_RD;
            wb_adr_o  <= '0;
            wb_dat_o  <= '0;
            wb_sel_o  <= '0;
            wb_we_o   <= 1'b0;
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            s_bresp   <= RESP_OKAY;
            s_bvalid  <= 1'b0;
            s_rresp   <= RESP_OKAY;
            s_rdata   <= '0;
            s_rvalid  <= 1'b0;
            timeout_o <= 1'b0;
        end else begin
            timeout_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (gnt_wr) begin
                        wb_adr_o <= s_awaddr;
                        wb_dat_o <= s_wdata;
                        wb_sel_o <= s_wstrb;
                        wb_we_o  <= 1'b1;
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                        last_gnt <= GNT_WR;
                        state    <= ST_WB_WR;
                    end else if (gnt_rd) begin
                        wb_adr_o <= s_araddr;
                        wb_sel_o <= '1;
                        wb_we_o  <= 1'b0;
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                        last_gnt <= GNT_RD;
                        state    <= ST_WB_RD;
                    end
                end
                ST_WB_WR, ST_WB_RD: begin
                    if (term) begin
                        wb_cyc_o  <= 1'b0;
                        wb_stb_o  <= 1'b0;
                        wb_we_o   <= 1'b0;
                        timeout_o <= !wb_ack_i && !wb_err_i;
                        if (state == ST_WB_WR) begin
                            s_bresp  <= term_resp;
                            s_bvalid <= 1'b1;
                            state    <= ST_B_RESP;
                        end else begin
                            s_rresp  <= term_resp;
                            s_rdata  <= wb_ack_i ? wb_dat_i : '0;
                            s_rvalid <= 1'b1;
                            state    <= ST_R_RESP;
                        end
                    end
                end
                ST_B_RESP: begin
                    if (s_bready) begin
                        s_bvalid <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                ST_R_RESP: begin
                    if (s_rready) begin
                        s_rvalid <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4l_wb_bridge.sv
// Self-checking bench for axi4l_wb_bridge (32-bit, TIMEOUT_CYCLES = 8).
// A table of single transactions feeds a scoreboard queue; a monitor pops
// and compares each AXI response together with the observed WB access.
// Hand-written sequences cover arbitration, timeout and mid-access reset.
module tb_axi4l_wb_bridge;

    localparam int unsigned TMO = 8;

    typedef struct {
        bit          is_wr;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [1:0]  resp;
        logic [31:0] rdata;
        int          cyc;   // expected cycles with cyc high, -1 = don't care
        int          lat;   // handshake to valid in cycles, -1 = don't care
    } exp_t;

    typedef struct {
        exp_t        e;
        int          mode;  // slave: 0 ack, 1 err, 2 silent
        int          ws;    // slave wait states
        logic [31:0] srd;   // slave read data
    } vec_t;

    logic        clk, rst_i;
    logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
    logic [3:0]  s_wstrb;
    logic        s_awvalid, s_awready, s_wvalid, s_wready;
    logic [1:0]  s_bresp, s_rresp;
    logic        s_bvalid, s_bready, s_arvalid, s_arready, s_rvalid, s_rready;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i, wb_err_i;
    logic        busy_o, timeout_o;

    axi4l_wb_bridge #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .s_awaddr  (s_awaddr),
        .s_awvalid (s_awvalid),
        .s_awready (s_awready),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_wvalid  (s_wvalid),
        .s_wready  (s_wready),
        .s_bresp   (s_bresp),
        .s_bvalid  (s_bvalid),
        .s_bready  (s_bready),
        .s_araddr  (s_araddr),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready),
        .wb_adr_o  (wb_adr_o),
        .wb_dat_o  (wb_dat_o),
        .wb_sel_o  (wb_sel_o),
        .wb_we_o   (wb_we_o),
        .wb_cyc_o  (wb_cyc_o),
        .wb_stb_o  (wb_stb_o),
        .wb_dat_i  (wb_dat_i),
        .wb_ack_i  (wb_ack_i),
        .wb_err_i  (wb_err_i),
        .busy_o    (busy_o),
        .timeout_o (timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- Wishbone slave model ----------------
    int          mode = 0;
    int          ws   = 0;
    logic [31:0] srd  = '0;
    int          wcnt;

    always @(posedge clk or posedge rst_i) begin
        if (rst_i || !wb_cyc_o) wcnt <= 0;
        else                    wcnt <= wcnt + 1;
    end

    assign wb_ack_i = wb_cyc_o && wb_stb_o && (mode == 0) && (wcnt >= ws);
    assign wb_err_i = wb_cyc_o && wb_stb_o && (mode == 1) && (wcnt >= ws);
    assign wb_dat_i = srd;

    // ---------------- Monitor / scoreboard ----------------
    exp_t        sb[$];
    int          cycle_no = 0;
    int          hs_cycle = 0;
    int          cyc_cnt  = 0;
    int          tcnt     = 0;
    logic [31:0] obs_adr, obs_dat;
    logic [3:0]  obs_sel;
    logic        obs_we;

    always @(posedge clk) cycle_no++;

    always @(negedge clk) begin
        exp_t e;
        if (rst_i) begin
            cyc_cnt = 0;
        end else begin
            if (timeout_o) tcnt++;
            if ((s_awvalid && s_awready) || (s_arvalid && s_arready)) hs_cycle = cycle_no;
            if (wb_cyc_o) begin
                if (cyc_cnt == 0) begin
                    obs_adr = wb_adr_o;
                    obs_dat = wb_dat_o;
                    obs_sel = wb_sel_o;
                    obs_we  = wb_we_o;
                end
                cyc_cnt++;
            end
            if ((s_bvalid && s_bready) || (s_rvalid && s_rready)) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_resp: got bvalid=%0b rvalid=%0b, expected no response", s_bvalid, s_rvalid);
                end else begin
                    e = sb.pop_front();
                    chk("resp_channel_is_write", 64'(s_bvalid), 64'(e.is_wr));
                    chk("wb_adr", 64'(obs_adr), 64'(e.adr));
                    if (e.is_wr) begin
                        chk("bresp", 64'(s_bresp), 64'(e.resp));
                        chk("wb_we_write", 64'(obs_we), 64'd1);
                        chk("wb_dat", 64'(obs_dat), 64'(e.dat));
                        chk("wb_sel_write", 64'(obs_sel), 64'(e.sel));
                    end else begin
                        chk("rresp", 64'(s_rresp), 64'(e.resp));
                        chk("rdata", 64'(s_rdata), 64'(e.rdata));
                        chk("wb_we_read", 64'(obs_we), 64'd0);
                        chk("wb_sel_read", 64'(obs_sel), 64'hF);
                    end
                    if (e.cyc >= 0) chk("cyc_cycles", 64'(cyc_cnt), 64'(e.cyc));
                    if (e.lat >= 0) chk("latency", 64'(cycle_no - hs_cycle), 64'(e.lat));
                end
                cyc_cnt = 0;
            end
        end
    end

    // ---------------- Stimulus helpers ----------------
    task automatic issue(input exp_t e, input bit push);
        bit done = 1'b0;
        if (push) sb.push_back(e);
        @(posedge clk); #1;
        if (e.is_wr) begin
            s_awaddr = e.adr; s_wdata = e.dat; s_wstrb = e.sel;
            s_awvalid = 1'b1; s_wvalid = 1'b1;
        end else begin
            s_araddr = e.adr; s_arvalid = 1'b1;
        end
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            done = e.is_wr ? s_awready : s_arready;
        end
        @(posedge clk); #1;
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
        chk("handshake_done", 64'(done), 64'd1);
    endtask

    task automatic drain();
        int i = 0;
        while (sb.size() != 0 && i < 100) begin
            @(negedge clk);
            i++;
        end
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    endtask

    // Write and read requested in the same cycle; write expected first.
    task automatic concurrent(input exp_t ew, input exp_t er);
        bit wr_done = 1'b0, rd_done = 1'b0, wr_hs, rd_hs;
        sb.push_back(ew);
        sb.push_back(er);
        @(posedge clk); #1;
        s_awaddr = ew.adr; s_wdata = ew.dat; s_wstrb = ew.sel;
        s_araddr = er.adr;
        s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
        for (int i = 0; i < 60 && !(wr_done && rd_done); i++) begin
            @(negedge clk);
            wr_hs = s_awvalid && s_awready;
            rd_hs = s_arvalid && s_arready;
            @(posedge clk); #1;
            if (wr_hs) begin s_awvalid = 1'b0; s_wvalid = 1'b0; wr_done = 1'b1; end
            if (rd_hs) begin s_arvalid = 1'b0; rd_done = 1'b1; end
        end
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
        chk("concurrent_handshakes", {62'd0, wr_done, rd_done}, 64'd3);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1, "watchdog");
    end

    // ---------------- Test sequence ----------------
    initial begin
        vec_t vecs[8];
        exp_t e, e2;
        int   t0;

        vecs[0] = '{'{1, 32'h10, 32'hDEADBEEF, 4'hF, 2'b00, 32'h0, 1, 2}, 0, 0, 32'h0};
        vecs[1] = '{'{0, 32'h14, 32'h0, 4'hF, 2'b00, 32'h12345678, 4, 5}, 0, 3, 32'h12345678};
        vecs[2] = '{'{1, 32'h20, 32'h01020304, 4'h5, 2'b00, 32'h0, 2, 3}, 0, 1, 32'h0};
        vecs[3] = '{'{0, 32'h24, 32'h0, 4'hF, 2'b00, 32'hA5A55A5A, 1, 2}, 0, 0, 32'hA5A55A5A};
        vecs[4] = '{'{1, 32'h30, 32'hFFFF0000, 4'hF, 2'b10, 32'h0, 1, 2}, 1, 0, 32'h0};
        vecs[5] = '{'{0, 32'h34, 32'h0, 4'hF, 2'b10, 32'h0, 3, 4}, 1, 2, 32'h87654321};
        vecs[6] = '{'{1, 32'h40, 32'h0BADF00D, 4'h8, 2'b00, 32'h0, 8, 9}, 0, 7, 32'h0};
        // ack lands in the same cycle the timeout would fire: ack wins
        vecs[7] = '{'{0, 32'h44, 32'h0, 4'hF, 2'b00, 32'h55AA33CC, 9, 10}, 0, 8, 32'h55AA33CC};

        s_awaddr = '0; s_wdata = '0; s_wstrb = '0; s_araddr = '0;
        s_bready = 1'b1; s_rready = 1'b1;
        s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
        rst_i = 1'b1;

        // Reset state, with requests pending
        repeat (2) @(negedge clk);
        chk("rst_awready", 64'(s_awready), 64'd0);
        chk("rst_arready", 64'(s_arready), 64'd0);
        chk("rst_wready", 64'(s_wready), 64'd0);
        chk("rst_cyc_stb", {62'd0, wb_cyc_o, wb_stb_o}, 64'd0);
        chk("rst_valids", {62'd0, s_bvalid, s_rvalid}, 64'd0);
        chk("rst_busy_timeout", {62'd0, busy_o, timeout_o}, 64'd0);
        chk("rst_rdata", 64'(s_rdata), 64'd0);
        chk("rst_wb_adr", 64'(wb_adr_o), 64'd0);
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
        @(posedge clk); #1;
        rst_i = 1'b0;

        // Table of single transactions
        t0 = tcnt;
        for (int i = 0; i < 8; i++) begin
            mode = vecs[i].mode;
            ws   = vecs[i].ws;
            srd  = vecs[i].srd;
            issue(vecs[i].e, 1'b1);
            drain();
        end
        chk("no_timeout_pulse_in_table", 64'(tcnt - t0), 64'd0);

        // Round-robin: W,R then W,R again
        mode = 0; ws = 0; srd = 32'hCAFEF00D;
        e  = '{1, 32'h60, 32'h11111111, 4'hF, 2'b00, 32'h0, 1, 2};
        e2 = '{0, 32'h64, 32'h0, 4'hF, 2'b00, 32'hCAFEF00D, 1, 2};
        concurrent(e, e2);
        e.adr = 32'h68; e.dat = 32'h22222222; e2.adr = 32'h6C;
        concurrent(e, e2);

        // Silent slave on a read: DECERR, rdata 0, response held until rready
        mode = 2; srd = 32'hFFFFFFFF; s_rready = 1'b0;
        t0 = tcnt;
        e = '{0, 32'h50, 32'h0, 4'hF, 2'b11, 32'h0, -1, -1};
        issue(e, 1'b1);
        for (int i = 0; i < 40 && !s_rvalid; i++) @(negedge clk);
        repeat (3) begin
            @(negedge clk);
            chk("timeout_rvalid_held", 64'(s_rvalid), 64'd1);
            chk("timeout_rresp_held", 64'(s_rresp), 64'h3);
            chk("timeout_busy_held", 64'(busy_o), 64'd1);
        end
        chk("timeout_pulse_count", 64'(tcnt - t0), 64'd1);
        @(posedge clk); #1;
        s_rready = 1'b1;
        drain();
        @(negedge clk);
        chk("timeout_busy_released", 64'(busy_o), 64'd0);

        // Asynchronous reset in the middle of a read
        s_bready = 1'b0; s_rready = 1'b0;
        e = '{0, 32'h70, 32'h0, 4'hF, 2'b00, 32'h0, -1, -1};
        issue(e, 1'b0);
        repeat (2) @(negedge clk);
        chk("pre_reset_cyc", 64'(wb_cyc_o), 64'd1);
        @(posedge clk); #3;
        rst_i = 1'b1;
        #1;
        chk("async_rst_cyc_stb", {62'd0, wb_cyc_o, wb_stb_o}, 64'd0);
        chk("async_rst_rvalid", 64'(s_rvalid), 64'd0);
        chk("async_rst_busy", 64'(busy_o), 64'd0);
        @(posedge clk); #1;
        rst_i = 1'b0;
        s_bready = 1'b1; s_rready = 1'b1;
        mode = 0; ws = 0; srd = 32'h0F0F1234;
        e = '{0, 32'h74, 32'h0, 4'hF, 2'b00, 32'h0F0F1234, 1, 2};
        issue(e, 1'b1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
